// File: rtl/booth_mul_arbiter_if.sv
// booth_mul_arbiter_if: request/response bundle for the arbitrated Booth multiplier
interface booth_mul_arbiter_if #(
  parameter int N  = 4,
  parameter int R  = 2,
  parameter int IW = (R > 1) ? $clog2(R) : 1
);
  logic [R-1:0]   req_valid;
  logic [R*N-1:0] req_m;
  logic [R*N-1:0] req_q;
  logic [R-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready;
  logic [2*N-1:0] resp_p;
  logic [IW-1:0]  resp_id;
  logic           busy;
  modport slave (
    input  req_valid, req_m, req_q, resp_ready,
    output req_ready, resp_valid, resp_p, resp_id, busy
  );
  modport master (
    output req_valid, req_m, req_q, resp_ready,
    input  req_ready, resp_valid, resp_p, resp_id, busy
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin arbitrated, shared iterative radix-2 Booth multiplier
module booth_mul_arbiter #(
  parameter int N = 4,
  parameter int R = 2
) (
  input logic clk,
  input logic rst,
  booth_mul_arbiter_if.slave bus
);
  localparam int IW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(N + 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0]     r_state;
  logic [N:0]     r_a;
  logic [N-1:0]   r_m;
  logic [N-1:0]   r_q;
  logic           r_q1;
  logic [CW-1:0]  r_cnt;
  logic [IW-1:0]  r_id;
  logic [IW-1:0]  r_last;
  logic           w_found;
  logic [IW-1:0]  w_gid;
  logic [IW-1:0]  w_idx;
  logic           w_acc;
  logic [N:0]     w_mx;
  logic [N:0]     w_sum;
  logic [R*N-1:0] w_msh;
  logic [R*N-1:0] w_qsh;
  // Round-robin search starting just after the last granted requester
  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    for (int k = 1; k <= R; k++) begin
      w_idx = IW'((int'(r_last) + k) % R);
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gid   = w_idx;
      end
    end
  end
  assign bus.req_ready = (r_state == IDLE && w_found) ? R'(1) << w_gid : '0;
  assign w_acc = |(bus.req_valid & bus.req_ready);
  assign w_msh = bus.req_m >> (N * w_gid);
  assign w_qsh = bus.req_q >> (N * w_gid);
  // A is one bit wider than M so that negating the most negative M cannot overflow
  assign w_mx  = {r_m[N-1], r_m};
  assign w_sum = ({r_q[0], r_q1} == 2'b01) ? r_a + w_mx :
                 ({r_q[0], r_q1} == 2'b10) ? r_a - w_mx : r_a;
  assign bus.resp_valid = r_state == DONE;
  assign bus.resp_p     = bus.resp_valid ? {r_a[N-1:0], r_q} : '0;
  assign bus.resp_id    = bus.resp_valid ? r_id : '0;
  assign bus.busy       = r_state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      r_id    <= '0;
      r_last  <= IW'(R - 1);
    end else if (r_state == IDLE) begin
      if (w_acc) begin
        r_state <= RUN;
        r_a     <= '0;
        r_m     <= w_msh[N-1:0];
        r_q     <= w_qsh[N-1:0];
        r_q1    <= 1'b0;
        r_cnt   <= CW'(N);
        r_id    <= w_gid;
        r_last  <= w_gid;
      end
    end else if (r_state == RUN) begin
      r_a   <= {w_sum[N], w_sum[N:1]};
      r_q   <= {w_sum[0], r_q[N-1:1]};
      r_q1  <= r_q[0];
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) r_state <= DONE;
    end else if (bus.resp_ready) begin
      r_state <= IDLE;
    end
  end
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: randomized scoreboard bench with a round-robin/product reference model
module tb_booth_mul_arbiter;
  localparam int N = 4;
  localparam int R = 2;
  typedef struct {int id; logic [2*N-1:0] p;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  booth_mul_arbiter_if #(.N(N), .R(R)) bus();
  booth_mul_arbiter #(.N(N), .R(R)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  exp_t sb[$];
  int tests = 0, fails = 0, cyc = 0, n_acc = 0, n_done = 0, last_g = R - 1, due = 0;
  bit m_idle = 1'b1, seen = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input bit ok, input string nm, input longint act, input longint expv);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask
  function automatic int pick(input logic [R-1:0] v, input int lg);
    for (int k = 1; k <= R; k++)
      if (((v >> ((lg + k) % R)) & R'(1)) != 0) return (lg + k) % R;
    return -1;
  endfunction
  function automatic logic [2*N-1:0] prod(input logic [N-1:0] a, input logic [N-1:0] b);
    int x;
    x = int'($signed(a)) * int'($signed(b));
    return x[2*N-1:0];
  endfunction
  // Predictor: decides the grant from round-robin rules and queues the exact product
  always @(negedge clk) begin : pred
    int g;
    logic [R-1:0] er;
    if (rst) begin
      sb.delete();
      m_idle = 1'b1;
      seen   = 1'b0;
      last_g = R - 1;
    end else begin
      g  = m_idle ? pick(bus.req_valid, last_g) : -1;
      er = (g >= 0) ? R'(1) << g : '0;
      chk(bus.req_ready == er, "grant", bus.req_ready, er);
      chk(bus.busy == !m_idle, "busy", bus.busy, !m_idle);
      if (g >= 0) begin
        sb.push_back('{g, prod(N'(bus.req_m >> (g * N)), N'(bus.req_q >> (g * N)))});
        last_g = g;
        m_idle = 1'b0;
        due    = cyc + 1 + N;
        n_acc++;
      end
    end
  end
  // Monitor: compares whatever the DUT presents against the queue head
  always @(negedge clk) begin : mon
    #1;
    if (!rst) begin
      if (bus.resp_valid) begin
        if (sb.size() == 0) chk(1'b0, "unexpected_resp", bus.resp_p, 0);
        else begin
          if (!seen) begin
            chk(cyc == due, "latency", cyc, due);
            seen = 1'b1;
          end
          chk(bus.resp_p == sb[0].p, "resp_p", bus.resp_p, sb[0].p);
          chk(int'(bus.resp_id) == sb[0].id, "resp_id", bus.resp_id, sb[0].id);
          if (bus.resp_ready) begin
            sb.delete(0);
            n_done++;
            m_idle = 1'b1;
            seen   = 1'b0;
          end
        end
      end else begin
        chk(bus.resp_p == '0 && bus.resp_id == '0, "resp_zero", bus.resp_p, 0);
        if (!m_idle && cyc == due) chk(1'b0, "missing_resp", 0, 1);
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(input string nm);
    chk({bus.req_ready, bus.resp_valid, bus.busy, bus.resp_p, bus.resp_id} == '0, nm,
        {bus.req_ready, bus.resp_valid, bus.busy, bus.resp_p, bus.resp_id}, 0);
  endtask
  task automatic wait_acc(input int at);
    int t = 0;
    while (n_acc < at && t < 20) begin tick(); t++; end
    chk(n_acc >= at, "accept_timeout", n_acc, at);
  endtask
  task automatic wait_done(input int dt);
    int t = 0;
    while (n_done < dt && t < 40) begin tick(); t++; end
    chk(n_done >= dt, "done_timeout", n_done, dt);
  endtask
  task automatic set_ops(input int id, input int m, input int q);
    logic [R*N-1:0] msk;
    msk = (R*N)'({N{1'b1}}) << (id * N);
    bus.req_m = ((R*N)'($urandom) & ~msk) | ((R*N)'(N'(m)) << (id * N));
    bus.req_q = ((R*N)'($urandom) & ~msk) | ((R*N)'(N'(q)) << (id * N));
  endtask
  task automatic do_one(input int id, input int m, input int q, input bit bp);
    int at, dt, t;
    at = n_acc + 1;
    dt = n_done + 1;
    bus.req_valid  = R'(1) << id;
    bus.resp_ready = !bp;
    set_ops(id, m, q);
    wait_acc(at);
    bus.req_valid = '0;
    bus.req_m = (R*N)'($urandom);
    bus.req_q = (R*N)'($urandom);
    if (bp) begin
      t = 0;
      while (!bus.resp_valid && t < 20) begin tick(); t++; end
      chk(bus.resp_valid, "resp_timeout", bus.resp_valid, 1);
      repeat (5) tick();
      bus.resp_ready = 1'b1;
    end
    wait_done(dt);
  endtask
  initial begin
    int at, dt, t;
    bus.req_valid = '0; bus.req_m = '0; bus.req_q = '0; bus.resp_ready = 1'b0;
    #1 chk_zero("reset_outputs");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    do_one(0, 3, 5, 1'b0);
    do_one(0, -3, 5, 1'b0);
    do_one(0, 7, -8, 1'b0);
    do_one(1, -8, -8, 1'b0);
    do_one(0, 0, -8, 1'b0);
    do_one(1, -1, 7, 1'b1);
    do_one(0, -8, 7, 1'b1);
    // Abort an operation after two iterations
    at = n_acc + 1;
    bus.req_valid = 2'b01; bus.resp_ready = 1'b1;
    set_ops(0, 5, -6);
    wait_acc(at);
    bus.req_valid = '0;
    repeat (2) tick();
    rst = 1'b1;
    #1 chk_zero("abort_outputs");
    tick();
    rst = 1'b0;
    at = n_acc + 1;
    dt = n_done + 1;
    bus.req_valid = '1;
    set_ops(0, -7, 3);
    set_ops(1, 2, 2);
    wait_acc(at);
    bus.req_valid = '0;
    wait_done(dt);
    // Both requesters contending: grants must alternate
    bus.req_valid = '1;
    bus.resp_ready = 1'b1;
    repeat (30) begin
      bus.req_m = (R*N)'($urandom);
      bus.req_q = (R*N)'($urandom);
      tick();
    end
    repeat (400) begin
      bus.req_valid  = R'($urandom);
      bus.req_m      = (R*N)'($urandom);
      bus.req_q      = (R*N)'($urandom);
      bus.resp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    t = 0;
    while (!(m_idle && sb.size() == 0) && t < 30) begin tick(); t++; end
    chk(m_idle && sb.size() == 0, "drain", sb.size(), 0);
    chk(n_done > 20, "throughput", n_done, 21);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/booth_mul_arbiter.md
BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the signed two's-complement operand width (N >= 2).
REQ-002 The block SHALL have parameter R, default 2, giving the number of requesters (R >= 2); IW = max(1, clog2(R)).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid  input  R  per-requester request-pending flag.
REQ-006 req_m  input  R*N  multiplicand; requester i occupies bits [i*N +: N].
REQ-007 req_q  input  R*N  multiplier; requester i occupies bits [i*N +: N].
REQ-008 req_ready  output  R  one-hot grant; accept of requester i = req_valid[i] & req_ready[i] at a rising edge.
REQ-009 resp_valid  output  1  product available.
REQ-010 resp_ready  input  1  consumer accepts the product.
REQ-011 resp_p  output  2N  signed product.
REQ-012 resp_id  output  IW  index of the requester that owns resp_p.
REQ-013 busy  output  1  high in every state other than IDLE.

Function
REQ-014 The block SHALL contain one iterative radix-2 Booth engine shared by all requesters, with states IDLE, RUN and DONE.
REQ-015 In IDLE, req_ready SHALL be combinational, one-hot, and SHALL select the first requester with req_valid high, searching from (last_grant+1) mod R upward with wrap-around; it SHALL be all-zero when no req_valid is high or when not in IDLE.
REQ-016 On an accept, the block SHALL latch M = req_m[i], Q = req_q[i], A = 0 (N+1 bits, sign-extended arithmetic), q1 = 0, count = N, id = i, last_grant = i, and SHALL go to RUN.
REQ-017 Each RUN cycle SHALL apply {Q[0],q1}: 01 -> A = A + M, 10 -> A = A - M, 00/11 -> A unchanged, then arithmetic-shift {A,Q,q1} right by one and decrement count.
REQ-018 A SHALL be N+1 bits wide so that M = -2^(N-1) does not overflow; resp_p SHALL equal the low 2N bits of {A,Q}, i.e. the exact product of m and q.
REQ-019 After the N-th RUN cycle the block SHALL enter DONE; resp_valid SHALL rise exactly N rising edges after the accept edge.
REQ-020 In DONE, resp_valid, resp_p and resp_id SHALL be high/stable until resp_ready is sampled high; on that edge the block SHALL return to IDLE.
REQ-021 No new request SHALL be accepted in RUN or DONE; the earliest next accept is the edge after the response handshake (back-to-back throughput: one product per N+2 cycles at resp_ready = 1).
REQ-022 Changes on req_m/req_q/req_valid after the accept edge SHALL NOT affect the in-flight product.
REQ-023 A requester that drops req_valid before being granted SHALL simply lose arbitration; no state is held for it.
REQ-024 resp_p and resp_id SHALL be zero whenever resp_valid is low.

Reset
REQ-025 While rst is high, the block SHALL asynchronously force state = IDLE, A, M, Q, q1, count, id to 0, last_grant = R-1 (so requester 0 wins first), req_ready = 0, resp_valid = 0, resp_p = 0, resp_id = 0, busy = 0.
REQ-026 Reset asserted in RUN or DONE SHALL abandon the operation; no response for it SHALL ever be issued.
REQ-027 The first accept SHALL be possible on the first rising edge after rst deasserts.

Verification (N=4, R=2 unless stated)
REQ-028 Requester 0: m=3, q=5, resp_ready=1 -> resp_valid rises 4 edges after accept, resp_p=0x0F, resp_id=0, then one cycle later busy=0.
REQ-029 Signed corners: (-3)*5 -> 0xF1; 7*(-8) -> 0xC8; (-8)*(-8) -> 0x40; 0*(-8) -> 0x00.
REQ-030 Both req_valid held high, resp_ready=1 -> grants alternate 0,1,0,1 with resp_id matching, each product correct.
REQ-031 resp_ready held low 5 cycles in DONE -> resp_valid, resp_p, resp_id stable all 5 cycles; req_ready=00 throughout; return to IDLE on the edge resp_ready=1.
REQ-032 rst pulsed mid-RUN (after 2 iterations) -> all outputs 0 immediately, no resp_valid for the aborted job; next request from requester 0 is granted first and completes correctly.
REQ-033 Operands changed on req_m/req_q one cycle after accept -> resp_p equals the product of the originally latched values.
